ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline, directly downstream of the ID/EX pipeline register; consumes its outputs.
- Contains:
  - operand forwarding muxes
  - immediate extension
  - single-cycle ALU with signed-overflow detection
  - iterative 32-cycle multiply/divide unit with HI/LO registers
  - EX/MEM pipeline register
- Raises stall_req to the hazard unit while a mult/div result is not yet available to a dependent instruction.

---
 rtl/ex_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module : ex_stage
// Desc   : Execute stage - forwarding, ALU, iterative mult/div, EX/MEM register
// Rev    : 1.0
// ============================================================================
module ex_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] busA_ex,
  input  logic [31:0] busB_ex,
  input  logic [15:0] imm16_ex,
  input  logic [4:0]  Rt_ex,
  input  logic [4:0]  Rd_ex,
  input  logic [5:0]  func_ex,
  input  logic        RegDst_ex,
  input  logic        ALUSrc_ex,
  input  logic        MemtoReg_ex,
  input  logic        RegWr_ex,
  input  logic        MemWr_ex,
  input  logic        ExtOp_ex,
  input  logic        R_type_ex,
  input  logic [2:0]  ALUop_ex,
  input  logic [1:0]  fwdA,
  input  logic [1:0]  fwdB,
  input  logic [31:0] mem_fwd,
  input  logic [31:0] wb_fwd,
  output logic        stall_req,
  output logic        ovf,
  output logic [31:0] alu_mem,
  output logic [31:0] busB_mem,
  output logic [4:0]  wr_reg_mem,
  output logic        RegWr_mem,
  output logic        MemWr_mem,
  output logic        MemtoReg_mem
);

  localparam int c_cnt_w = $clog2(MD_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  logic [31:0] a_op, b_fwd, b_op, imm_ext, sum, diff;
  logic        add_ovf, sub_ovf, slt_s, slt_u;

  always_comb begin
    case (fwdA)
      2'b01:   a_op = mem_fwd;
      2'b10:   a_op = wb_fwd;
      default: a_op = busA_ex;
    endcase
    case (fwdB)
      2'b01:   b_fwd = mem_fwd;
      2'b10:   b_fwd = wb_fwd;
      default: b_fwd = busB_ex;
    endcase
  end

  assign imm_ext = ExtOp_ex ? {{16{imm16_ex[15]}}, imm16_ex} : {16'h0000, imm16_ex};
  assign b_op    = ALUSrc_ex ? imm_ext : b_fwd;
  assign sum     = a_op + b_op;
  assign diff    = a_op - b_op;
  assign add_ovf = (a_op[31] == b_op[31]) && (sum[31] != a_op[31]);
  assign sub_ovf = (a_op[31] != b_op[31]) && (diff[31] != a_op[31]);
  assign slt_s   = $signed(a_op) < $signed(b_op);
  assign slt_u   = a_op < b_op;

  md_state_e          md_state_q, md_state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [31:0]        opd_q, opd_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, rem_neg_q, rem_neg_d, dbz_q, dbz_d;

  logic [31:0] alu_res;
  logic        res_ok, chk_add, chk_sub, is_md, md_mul, md_signed, rd_hilo, bubble;

  always_comb begin
    alu_res   = 32'h0;
    res_ok    = 1'b1;
    chk_add   = 1'b0;
    chk_sub   = 1'b0;
    is_md     = 1'b0;
    md_mul    = 1'b0;
    md_signed = 1'b0;
    rd_hilo   = 1'b0;
    if (R_type_ex) begin
      case (func_ex)
        6'h20: begin alu_res = sum;  chk_add = 1'b1; end
        6'h21: alu_res = sum;
        6'h22: begin alu_res = diff; chk_sub = 1'b1; end
        6'h23: alu_res = diff;
        6'h24: alu_res = a_op & b_op;
        6'h25: alu_res = a_op | b_op;
        6'h26: alu_res = a_op ^ b_op;
        6'h27: alu_res = ~(a_op | b_op);
        6'h2A: alu_res = {31'h0, slt_s};
        6'h2B: alu_res = {31'h0, slt_u};
        6'h10: begin alu_res = hi_q; rd_hilo = 1'b1; end
        6'h12: begin alu_res = lo_q; rd_hilo = 1'b1; end
        6'h18: begin is_md = 1'b1; md_mul = 1'b1; md_signed = 1'b1; end
        6'h19: begin is_md = 1'b1; md_mul = 1'b1; end
        6'h1A: begin is_md = 1'b1; md_signed = 1'b1; end
        6'h1B: is_md = 1'b1;
        default: res_ok = 1'b0;
      endcase
    end else begin
      case (ALUop_ex)
        3'b000:  begin alu_res = sum;  chk_add = 1'b1; end
        3'b001:  begin alu_res = diff; chk_sub = 1'b1; end
        3'b010:  alu_res = a_op & b_op;
        3'b011:  alu_res = a_op | b_op;
        3'b100:  alu_res = {31'h0, slt_s};
        3'b101:  alu_res = {31'h0, slt_u};
        3'b110:  alu_res = {imm16_ex, 16'h0000};
        default: alu_res = a_op ^ b_op;
      endcase
    end
  end

  assign ovf       = (chk_add & add_ovf) | (chk_sub & sub_ovf);
  assign stall_req = (md_state_q != MD_IDLE) & (is_md | rd_hilo);
  // A mult/div never writes a register itself, so it always leaves a bubble.
  assign bubble    = stall_req | is_md;

  logic [32:0] mul_sum, rem_sh;
  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
  logic [63:0] prod;
  logic        div_ge, a_sgn, b_sgn;

  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : 33'h0);
  assign mul_hi  = mul_sum[32:1];
  assign mul_lo  = {mul_sum[0], acc_lo_q[31:1]};
  assign prod    = {mul_hi, mul_lo};
  // Restoring step: a successful subtract always leaves a remainder below the divisor.
  assign rem_sh  = {acc_hi_q, acc_lo_q[31]};
  assign div_ge  = rem_sh >= {1'b0, opd_q};
  assign div_hi  = div_ge ? (rem_sh[31:0] - opd_q) : rem_sh[31:0];
  assign div_lo  = {acc_lo_q[30:0], div_ge};
  assign a_sgn   = md_signed & a_op[31];
  assign b_sgn   = md_signed & b_op[31];

  always_comb begin
    md_state_d = md_state_q;
    cnt_d      = cnt_q;
    opd_d      = opd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (md_state_q)
      MD_IDLE: begin
        if (is_md) begin
          md_state_d = md_mul ? MD_MUL : MD_DIV;
          cnt_d      = '0;
          opd_d      = b_sgn ? -b_op : b_op;
          acc_hi_d   = 32'h0;
          acc_lo_d   = a_sgn ? -a_op : a_op;
          neg_d      = a_sgn ^ b_sgn;
          rem_neg_d  = a_sgn;
          dbz_d      = (b_op == 32'h0);
        end
      end
      MD_MUL: begin
        cnt_d    = cnt_q + c_cnt_w'(1);
        acc_hi_d = mul_hi;
        acc_lo_d = mul_lo;
        if (cnt_q == c_last) begin
          md_state_d   = MD_IDLE;
          {hi_d, lo_d} = neg_q ? -prod : prod;
        end
      end
      MD_DIV: begin
        cnt_d    = cnt_q + c_cnt_w'(1);
        acc_hi_d = div_hi;
        acc_lo_d = div_lo;
        if (cnt_q == c_last) begin
          md_state_d = MD_IDLE;
          lo_d       = dbz_q ? 32'hFFFF_FFFF : (neg_q ? -div_lo : div_lo);
          hi_d       = rem_neg_q ? -div_hi : div_hi;
        end
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state_q <= MD_IDLE;
      cnt_q      <= '0;
      opd_q      <= 32'h0;
      acc_hi_q   <= 32'h0;
      acc_lo_q   <= 32'h0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
    end else begin
      md_state_q <= md_state_d;
      cnt_q      <= cnt_d;
      opd_q      <= opd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  logic [31:0] alu_mem_q, busB_mem_q;
  logic [4:0]  wr_reg_mem_q;
  logic        reg_wr_mem_q, mem_wr_mem_q, mem_to_reg_mem_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_mem_q        <= 32'h0;
      busB_mem_q       <= 32'h0;
      wr_reg_mem_q     <= 5'h0;
      reg_wr_mem_q     <= 1'b0;
      mem_wr_mem_q     <= 1'b0;
      mem_to_reg_mem_q <= 1'b0;
    end else begin
      alu_mem_q        <= alu_res;
      busB_mem_q       <= b_fwd;
      wr_reg_mem_q     <= RegDst_ex ? Rd_ex : Rt_ex;
      reg_wr_mem_q     <= RegWr_ex & res_ok & ~ovf & ~bubble;
      mem_wr_mem_q     <= MemWr_ex & ~bubble;
      mem_to_reg_mem_q <= MemtoReg_ex & ~bubble;
    end
  end

  assign alu_mem      = alu_mem_q;
  assign busB_mem     = busB_mem_q;
  assign wr_reg_mem   = wr_reg_mem_q;
  assign RegWr_mem    = reg_wr_mem_q;
  assign MemWr_mem    = mem_wr_mem_q;
  assign MemtoReg_mem = mem_to_reg_mem_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_stage
// Desc   : Scoreboard bench for ex_stage; MemtoReg_ex marks checked instructions
// Rev    : 1.0
// ============================================================================
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] busA_ex, busB_ex, mem_fwd, wb_fwd;
  logic [15:0] imm16_ex;
  logic [4:0]  Rt_ex, Rd_ex;
  logic [5:0]  func_ex;
  logic        RegDst_ex, ALUSrc_ex, MemtoReg_ex, RegWr_ex, MemWr_ex, ExtOp_ex, R_type_ex;
  logic [2:0]  ALUop_ex;
  logic [1:0]  fwdA, fwdB;
  logic        stall_req, ovf;
  logic [31:0] alu_mem, busB_mem;
  logic [4:0]  wr_reg_mem;
  logic        RegWr_mem, MemWr_mem, MemtoReg_mem;

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .busA_ex(busA_ex), .busB_ex(busB_ex), .imm16_ex(imm16_ex),
    .Rt_ex(Rt_ex), .Rd_ex(Rd_ex), .func_ex(func_ex),
    .RegDst_ex(RegDst_ex), .ALUSrc_ex(ALUSrc_ex), .MemtoReg_ex(MemtoReg_ex),
    .RegWr_ex(RegWr_ex), .MemWr_ex(MemWr_ex), .ExtOp_ex(ExtOp_ex), .R_type_ex(R_type_ex),
    .ALUop_ex(ALUop_ex), .fwdA(fwdA), .fwdB(fwdB), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .stall_req(stall_req), .ovf(ovf), .alu_mem(alu_mem), .busB_mem(busB_mem),
    .wr_reg_mem(wr_reg_mem), .RegWr_mem(RegWr_mem), .MemWr_mem(MemWr_mem),
    .MemtoReg_mem(MemtoReg_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] bb;
    logic [4:0]  wr;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every marked instruction leaving EX shows up as MemtoReg_mem=1.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && MemtoReg_mem === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got alu_mem=%h, expected no output", alu_mem);
        end else begin
          mon_e = exp_q.pop_front();
          check32({mon_e.name, ".alu"},   alu_mem,            mon_e.alu);
          check32({mon_e.name, ".regwr"}, {31'h0, RegWr_mem}, {31'h0, mon_e.rw});
          check32({mon_e.name, ".wr"},    {27'h0, wr_reg_mem}, {27'h0, mon_e.wr});
          check32({mon_e.name, ".busB"},  busB_mem,           mon_e.bb);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    R_type_ex = 1'b1; func_ex = 6'h00; busA_ex = 32'h0; busB_ex = 32'h0; imm16_ex = 16'h0;
    Rt_ex = 5'd3; Rd_ex = 5'd9; RegDst_ex = 1'b1; ALUSrc_ex = 1'b0; MemtoReg_ex = 1'b0;
    RegWr_ex = 1'b0; MemWr_ex = 1'b0; ExtOp_ex = 1'b0; ALUop_ex = 3'b000;
    fwdA = 2'b00; fwdB = 2'b00;
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    clr();
    func_ex = f; busA_ex = a; busB_ex = b; RegWr_ex = 1'b1; MemtoReg_ex = 1'b1;
  endtask

  task automatic set_i(input logic [2:0] op, input logic [31:0] a, input logic [15:0] imm,
                       input logic ext);
    clr();
    R_type_ex = 1'b0; ALUop_ex = op; busA_ex = a; busB_ex = 32'h0000_1234; imm16_ex = imm;
    ExtOp_ex = ext; ALUSrc_ex = 1'b1; RegDst_ex = 1'b0; RegWr_ex = 1'b1; MemtoReg_ex = 1'b1;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] alu, input logic rw,
                            input logic [4:0] wr, input logic [31:0] bb);
    exp_t e;
    e.name = nm; e.alu = alu; e.rw = rw; e.wr = wr; e.bb = bb;
    exp_q.push_back(e);
  endtask

  task automatic run_alu(input string nm, input logic [31:0] alu, input logic rw,
                         input logic ov, input logic [4:0] wr, input logic [31:0] bb);
    expect_out(nm, alu, rw, wr, bb);
    #1;
    check32({nm, ".ovf"},   {31'h0, ovf},       {31'h0, ov});
    check32({nm, ".stall"}, {31'h0, stall_req}, 32'h0);
    tick();
  endtask

  task automatic issue_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    set_r(f, a, b);
    #1;
    check32({nm, ".issue_stall"}, {31'h0, stall_req}, 32'h0);
    tick();
  endtask

  task automatic wait_stall(input string nm, input int exp_cycles);
    int n = 0;
    #1;
    while (stall_req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check32({nm, ".stall_cycles"}, n, exp_cycles);
  endtask

  task automatic rd_hilo(input string nm, input logic [5:0] f, input logic [31:0] v,
                         input int stalls);
    set_r(f, 32'h0, 32'h0);
    expect_out(nm, v, 1'b1, 5'd9, 32'h0);
    wait_stall(nm, stalls);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_fwd = 32'h0;
    wb_fwd = 32'h0;
    clr();
    repeat (3) @(negedge clk);
    #2;
    check32("rst.alu_mem",  alu_mem,  32'h0);
    check32("rst.busB_mem", busB_mem, 32'h0);
    check32("rst.ctrl", {24'h0, wr_reg_mem, RegWr_mem, MemWr_mem, MemtoReg_mem}, 32'h0);
    check32("rst.stall", {31'h0, stall_req}, 32'h0);
    rst_n = 1'b1;
    tick();

    set_r(6'h20, 32'h0000_1234, 32'h1); fwdA = 2'b01; mem_fwd = 32'h7FFF_FFFF;
    run_alu("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 5'd9, 32'h1);
    set_r(6'h21, 32'h0000_1234, 32'h1); fwdA = 2'b01;
    run_alu("addu", 32'h8000_0000, 1'b1, 1'b0, 5'd9, 32'h1);
    set_i(3'b000, 32'd5, 16'hFFFE, 1'b1);
    run_alu("addi_sext", 32'h0000_0003, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_i(3'b000, 32'd5, 16'hFFFE, 1'b0);
    run_alu("addi_zext", 32'h0001_0003, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_i(3'b110, 32'd5, 16'hFFFE, 1'b1);
    run_alu("lui", 32'hFFFE_0000, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_i(3'b111, 32'h0F0F_0F0F, 16'h00FF, 1'b0);
    run_alu("xori", 32'h0F0F_0FF0, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_i(3'b001, 32'h8000_0000, 16'h0001, 1'b1);
    run_alu("subi_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 5'd3, 32'h1234);
    set_i(3'b100, 32'hFFFF_FFFF, 16'h0001, 1'b1);
    run_alu("slti", 32'h1, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_i(3'b101, 32'hFFFF_FFFF, 16'h0001, 1'b1);
    run_alu("sltiu", 32'h0, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_i(3'b010, 32'hF0F0_F0F0, 16'hFF00, 1'b1);
    run_alu("andi", 32'hF0F0_F000, 1'b1, 1'b0, 5'd3, 32'h1234);
    set_r(6'h22, 32'd5, 32'd7);
    run_alu("sub", 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd9, 32'd7);
    set_r(6'h27, 32'h0F0F_0000, 32'h00FF_0000);
    run_alu("nor", 32'hF000_FFFF, 1'b1, 1'b0, 5'd9, 32'h00FF_0000);
    set_r(6'h2A, 32'd1, 32'hFFFF_FFFF);
    run_alu("slt", 32'h0, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF);
    set_r(6'h2B, 32'd1, 32'hFFFF_FFFF);
    run_alu("sltu", 32'h1, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF);
    set_r(6'h25, 32'h1, 32'h99); fwdB = 2'b10; wb_fwd = 32'h10;
    run_alu("or_fwdB_wb", 32'h11, 1'b1, 1'b0, 5'd9, 32'h10);
    set_r(6'h21, 32'd3, 32'd4); fwdA = 2'b11; mem_fwd = 32'h100;
    run_alu("fwd_reserved", 32'd7, 1'b1, 1'b0, 5'd9, 32'd4);
    set_r(6'h3F, 32'd5, 32'd5);
    run_alu("bad_func", 32'h0, 1'b0, 1'b0, 5'd9, 32'd5);

    issue_md("mult1", 6'h18, 32'hFFFF_FFFD, 32'd7);
    rd_hilo("mfhi_mult1", 6'h10, 32'hFFFF_FFFF, 32);
    rd_hilo("mflo_mult1", 6'h12, 32'hFFFF_FFEB, 0);

    issue_md("mult2", 6'h18, 32'hFFFF_FFFF, 32'd2);
    set_r(6'h25, 32'hF0, 32'h0F);
    run_alu("or_during_mul", 32'hFF, 1'b1, 1'b0, 5'd9, 32'h0F);
    rd_hilo("mflo_mult2", 6'h12, 32'hFFFF_FFFE, 31);
    rd_hilo("mfhi_mult2", 6'h10, 32'hFFFF_FFFF, 0);

    issue_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    rd_hilo("mfhi_div", 6'h10, 32'hFFFF_FFFF, 32);
    rd_hilo("mflo_div", 6'h12, 32'hFFFF_FFFD, 0);

    issue_md("divu0", 6'h1B, 32'd7, 32'd0);
    rd_hilo("mflo_divu0", 6'h12, 32'hFFFF_FFFF, 32);
    rd_hilo("mfhi_divu0", 6'h10, 32'h0000_0007, 0);

    issue_md("multu3", 6'h19, 32'h0001_0000, 32'h0001_0003);
    set_r(6'h1B, 32'd100, 32'd7);
    wait_stall("divu_after_mult", 32);
    tick();
    rd_hilo("mfhi_divu3", 6'h10, 32'd2, 32);
    rd_hilo("mflo_divu3", 6'h12, 32'd14, 0);

    issue_md("mult_rst", 6'h18, 32'd5, 32'd5);
    set_r(6'h25, 32'hF0, 32'h0F);
    run_alu("or_pre_rst", 32'hFF, 1'b1, 1'b0, 5'd9, 32'h0F);
    clr();
    repeat (7) tick();
    set_r(6'h24, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_alu("and_pre_rst", 32'h0F00_0F00, 1'b1, 1'b0, 5'd9, 32'h0FF0_0FF0);
    set_r(6'h10, 32'h0, 32'h0);
    #1;
    check32("mid_mul.stall", {31'h0, stall_req}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check32("rst_mid.alu_mem",  alu_mem,  32'h0);
    check32("rst_mid.busB_mem", busB_mem, 32'h0);
    check32("rst_mid.ctrl", {24'h0, wr_reg_mem, RegWr_mem, MemWr_mem, MemtoReg_mem}, 32'h0);
    check32("rst_mid.stall", {31'h0, stall_req}, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    expect_out("mfhi_after_rst", 32'h0, 1'b1, 5'd9, 32'h0);
    wait_stall("mfhi_after_rst", 0);
    tick();
    rd_hilo("mflo_after_rst", 6'h12, 32'h0, 0);

    clr();
    tick();
    tick();
    @(posedge clk);
    #1;
    check32("scoreboard_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
